// File: rtl/hazard_scoreboard.sv
// Register-hazard scoreboard between decode and the scalar/vector register files.
// Tracks in-flight destinations, stalls decode on RAW/WAW/full, clears at writeback.
module hazard_scoreboard #(
    parameter int NREG         = 16,
    parameter int MAX_INFLIGHT = 4,
    parameter int WB_BYPASS    = 1,
    localparam int AW          = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            issue_valid,
    input  logic            src1_en,
    input  logic            src1_type,
    input  logic [AW-1:0]   src1_addr,
    input  logic            src2_en,
    input  logic            src2_type,
    input  logic [AW-1:0]   src2_addr,
    input  logic            dst_en,
    input  logic            dst_type,
    input  logic [AW-1:0]   dst_addr,
    output logic            issue_stall,
    output logic            issue_fire,
    input  logic            wb_valid,
    input  logic            wb_type,
    input  logic [AW-1:0]   wb_addr,
    input  logic            flush,
    output logic [NREG-1:0] busy_scalar,
    output logic [NREG-1:0] busy_vector,
    output logic [4:0]      inflight_cnt,
    output logic [15:0]     stall_cycles,
    output logic            err_spurious
);

    function automatic logic is_busy(input logic [NREG-1:0] s, input logic [NREG-1:0] v,
                                     input logic t, input logic [AW-1:0] a);
        return t ? v[a] : s[a];
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] val, input logic inc);
        return (inc && (val != 16'hFFFF)) ? val + 16'd1 : val;
    endfunction

    logic            byp_en;
    logic            wb_busy, wb_clr;
    logic            byp1, byp2, raw, waw, full;
    logic            set_any;
    logic [NREG-1:0] clr_s, clr_v, set_s, set_v;
    logic [4:0]      cnt_next;

    assign byp_en = (WB_BYPASS != 0);

    always_comb begin
        wb_busy = is_busy(busy_scalar, busy_vector, wb_type, wb_addr);
        wb_clr  = wb_valid & wb_busy;
        // A writeback landing this cycle hides the source hit when bypass is enabled
        byp1 = byp_en & wb_valid & (wb_type == src1_type) & (wb_addr == src1_addr);
        byp2 = byp_en & wb_valid & (wb_type == src2_type) & (wb_addr == src2_addr);
        raw  = (src1_en & is_busy(busy_scalar, busy_vector, src1_type, src1_addr) & ~byp1) |
               (src2_en & is_busy(busy_scalar, busy_vector, src2_type, src2_addr) & ~byp2);
        waw  = dst_en & is_busy(busy_scalar, busy_vector, dst_type, dst_addr);
        full = (inflight_cnt == 5'(MAX_INFLIGHT)) & dst_en & ~wb_clr;
        issue_stall = issue_valid & (raw | waw | full | flush);
        issue_fire  = issue_valid & ~issue_stall;
    end

    always_comb begin
        clr_s   = '0;
        clr_v   = '0;
        set_s   = '0;
        set_v   = '0;
        set_any = issue_fire & dst_en;
        if (wb_clr) begin
            if (wb_type) clr_v[wb_addr] = 1'b1;
            else         clr_s[wb_addr] = 1'b1;
        end
        if (set_any) begin
            if (dst_type) set_v[dst_addr] = 1'b1;
            else          set_s[dst_addr] = 1'b1;
        end
        cnt_next = inflight_cnt + {4'd0, set_any} - {4'd0, wb_clr};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_scalar  <= '0;
            busy_vector  <= '0;
            inflight_cnt <= '0;
            stall_cycles <= '0;
            err_spurious <= 1'b0;
        end else begin
            stall_cycles <= sat_inc(stall_cycles, issue_valid & issue_stall);
            if (flush) begin
                busy_scalar  <= '0;
                busy_vector  <= '0;
                inflight_cnt <= '0;
            end else begin
                // Clear before set so a same-cycle set always wins
                busy_scalar  <= (busy_scalar & ~clr_s) | set_s;
                busy_vector  <= (busy_vector & ~clr_v) | set_v;
                inflight_cnt <= cnt_next;
                if (wb_valid & ~wb_busy) err_spurious <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: driver pushes model expectations,
// a monitor pops and compares them against the DUT each cycle.
module tb_hazard_scoreboard;
    localparam int NREG = 16;
    localparam int MAXI = 4;
    localparam int BYP  = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_valid = 0, src1_en = 0, src1_type = 0, src2_en = 0, src2_type = 0;
    logic        dst_en = 0, dst_type = 0, wb_valid = 0, wb_type = 0, flush = 0;
    logic [3:0]  src1_addr = 0, src2_addr = 0, dst_addr = 0, wb_addr = 0;
    logic        issue_stall, issue_fire, err_spurious;
    logic [15:0] busy_scalar, busy_vector, stall_cycles;
    logic [4:0]  inflight_cnt;

    always #5 clk = ~clk;

    hazard_scoreboard #(.NREG(NREG), .MAX_INFLIGHT(MAXI), .WB_BYPASS(BYP)) dut (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid),
        .src1_en(src1_en), .src1_type(src1_type), .src1_addr(src1_addr),
        .src2_en(src2_en), .src2_type(src2_type), .src2_addr(src2_addr),
        .dst_en(dst_en), .dst_type(dst_type), .dst_addr(dst_addr),
        .issue_stall(issue_stall), .issue_fire(issue_fire),
        .wb_valid(wb_valid), .wb_type(wb_type), .wb_addr(wb_addr), .flush(flush),
        .busy_scalar(busy_scalar), .busy_vector(busy_vector), .inflight_cnt(inflight_cnt),
        .stall_cycles(stall_cycles), .err_spurious(err_spurious)
    );

    typedef struct {
        logic        stall, fire, err;
        logic [15:0] bs, bv, sc;
        logic [4:0]  cnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference state: a set of in-flight registers plus plain counters
    bit   mb[2][NREG];
    int   msc;
    bit   merr;

    function automatic int pop_busy();
        int n = 0;
        for (int t = 0; t < 2; t++)
            for (int a = 0; a < NREG; a++) n += mb[t][a];
        return n;
    endfunction

    function automatic void model_clear(input bit full_reset);
        for (int t = 0; t < 2; t++)
            for (int a = 0; a < NREG; a++) mb[t][a] = 0;
        if (full_reset) begin
            msc  = 0;
            merr = 0;
        end
    endfunction

    task automatic model_step(input bit push);
        int   st1 = int'(src1_type), st2 = int'(src2_type), dt = int'(dst_type), wt = int'(wb_type);
        bit   wbb, r1, r2, waw, full, st, fr;
        exp_t e;
        wbb  = wb_valid && mb[wt][wb_addr];
        r1   = src1_en && mb[st1][src1_addr] &&
               !(BYP != 0 && wb_valid && wt == st1 && wb_addr == src1_addr);
        r2   = src2_en && mb[st2][src2_addr] &&
               !(BYP != 0 && wb_valid && wt == st2 && wb_addr == src2_addr);
        waw  = dst_en && mb[dt][dst_addr];
        full = (pop_busy() == MAXI) && dst_en && !wbb;
        st   = issue_valid && (r1 || r2 || waw || full || flush);
        fr   = issue_valid && !st;
        if (push) begin
            e.stall = st;
            e.fire  = fr;
            e.err   = merr;
            e.sc    = 16'(msc);
            e.cnt   = 5'(pop_busy());
            for (int a = 0; a < NREG; a++) begin
                e.bs[a] = mb[0][a];
                e.bv[a] = mb[1][a];
            end
            q.push_back(e);
        end
        if (st && msc < 65535) msc++;
        if (flush) model_clear(0);
        else begin
            if (wb_valid) begin
                if (mb[wt][wb_addr]) mb[wt][wb_addr] = 0;
                else merr = 1;
            end
            if (fr && dst_en) mb[dt][dst_addr] = 1;
        end
    endtask

    task automatic drv(input bit iv, input bit s1e, input bit s1t, input int s1a,
                       input bit s2e, input bit s2t, input int s2a,
                       input bit de, input bit dt, input int da,
                       input bit wv, input bit wt, input int wa, input bit fl,
                       input bit push = 1);
        @(negedge clk);
        #1;
        issue_valid = iv;
        src1_en = s1e; src1_type = s1t; src1_addr = 4'(s1a);
        src2_en = s2e; src2_type = s2t; src2_addr = 4'(s2a);
        dst_en  = de;  dst_type  = dt;  dst_addr  = 4'(da);
        wb_valid = wv; wb_type = wt; wb_addr = 4'(wa);
        flush = fl;
        model_step(push);
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 0;
        issue_valid = 0; src1_en = 0; src2_en = 0; dst_en = 0; wb_valid = 0; flush = 0;
        model_clear(1);
        model_step(1);
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("issue_stall", 32'(issue_stall), 32'(e.stall));
                chk("issue_fire", 32'(issue_fire), 32'(e.fire));
                chk("busy_scalar", 32'(busy_scalar), 32'(e.bs));
                chk("busy_vector", 32'(busy_vector), 32'(e.bv));
                chk("inflight_cnt", 32'(inflight_cnt), 32'(e.cnt));
                chk("stall_cycles", 32'(stall_cycles), 32'(e.sc));
                chk("err_spurious", 32'(err_spurious), 32'(e.err));
            end
        end
    end

    initial begin : stimulus
        do_reset();

        // Randomized traffic over a small register window to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            bit wv, wt;
            int wa;
            wv = ($urandom_range(0, 99) < 60);
            wt = 1'($urandom_range(0, 1));
            wa = $urandom_range(0, 5);
            if (wv && $urandom_range(0, 9) < 8) begin
                for (int k = 0; k < 2 * NREG; k++) begin
                    int t = (k / NREG) ^ int'(wt);
                    int a = (k + wa) % NREG;
                    if (mb[t][a]) begin
                        wt = 1'(t);
                        wa = a;
                        break;
                    end
                end
            end
            drv($urandom_range(0, 99) < 80,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 5),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 5),
                $urandom_range(0, 99) < 70, 1'($urandom_range(0, 1)), $urandom_range(0, 5),
                wv, wt, wa, $urandom_range(0, 99) < 3);
            if (n % 700 == 699) do_reset();
        end

        // RAW stall until writeback, bypass releases it in the same cycle
        do_reset();
        drv(1, 0, 0, 0, 0, 0, 0, 1, 0, 3, 0, 0, 0, 0);
        drv(1, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drv(1, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drv(1, 1, 0, 3, 0, 0, 0, 0, 0, 0, 1, 0, 3, 0);
        idle();

        // Scalar and vector entries with the same address are independent
        do_reset();
        drv(1, 0, 0, 0, 0, 0, 0, 1, 0, 5, 0, 0, 0, 0);
        drv(1, 1, 1, 5, 0, 0, 0, 1, 1, 5, 0, 0, 0, 0);
        idle();

        // In-flight limit, released by a same-cycle writeback
        do_reset();
        for (int r = 0; r < 4; r++) drv(1, 0, 0, 0, 0, 0, 0, 1, 0, r, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0, 0, 1, 0, 4, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0, 0, 1, 0, 4, 1, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();

        // Flush with issue pending
        do_reset();
        for (int r = 0; r < 3; r++) drv(1, 0, 0, 0, 0, 0, 0, 1, 1, r, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0, 0, 1, 0, 7, 0, 0, 0, 1);
        idle();

        // Spurious writeback is sticky, then reset in the middle of a stall
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 9, 0);
        idle();
        drv(1, 0, 0, 0, 0, 0, 0, 1, 0, 3, 0, 0, 0, 0);
        drv(1, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        idle();

        // Long WAW stall drives the stall counter into saturation
        drv(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        for (int n = 0; n < 70000; n++) drv(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        idle();

        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
